param_updown_counter: RTL and testbench

PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

---
 rtl/counter_pkg.sv | 5 +
 rtl/tick_prescaler.sv | 26 ++
 rtl/param_updown_counter.sv | 73 +++++++
 tb/tb_param_updown_counter.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants for the up/down counter family: limit-behaviour mode selectors.
package counter_pkg;
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;
endpackage

// File: rtl/tick_prescaler.sv
// Enable divider: asserts tick on every PRESCALE-th enabled cycle and freezes its phase while en=0.
module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic en,
  output logic tick
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] phase;

  // With PRESCALE=1 LAST is 0, so phase never leaves 0 and tick simply follows en.
  assign tick = en && (phase == LAST);

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      phase <= '0;
    end else if (en) begin
      phase <= tick ? '0 : phase + 1'b1;
    end
  end
endmodule

// File: rtl/param_updown_counter.sv
// Prescaled up/down counter with programmable top value and wrap or saturate behaviour at the limits.
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter int               PRESCALE = 1,
  parameter int               MODE     = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             sat
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic tick;
  logic at_lim;
  logic step;

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAX_VAL) ? MAX_VAL : v;
  endfunction

  // A clear or load re-phases the prescaler so the next step is a full PRESCALE cycles away.
  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .restart(clear | load),
    .en     (en),
    .tick   (tick)
  );

  assign at_lim = up ? (count == MAX_VAL) : (count == '0);
  assign tc     = at_lim;
  assign step   = en && tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      wrap  <= 1'b0;
      sat   <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clear) begin
        count <= '0;
        sat   <= 1'b0;
      end else if (load) begin
        count <= clamp_load(load_val);
        sat   <= 1'b0;
      end else if (step) begin
        if (!at_lim) begin
          count <= up ? count + ONE : count - ONE;
          sat   <= 1'b0;
        end else if (MODE == MODE_SAT) begin
          sat <= 1'b1;
        end else begin
          count <= up ? '0 : MAX_VAL;
          wrap  <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_param_updown_counter.sv
// Scoreboard bench: three counter variants share stimulus; each vector queues the expected outputs of one variant.
module tb_param_updown_counter;
  import counter_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0, en = 1'b0, up = 1'b0, load = 1'b0, clear = 1'b0;
  logic [3:0] load_val = '0;

  logic [3:0] c0, c1, c2;
  logic       t0, t1, t2, w0, w1, w2, s0, s1, s2;

  typedef struct {
    int         id;
    logic [6:0] exp;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  param_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .PRESCALE(1), .MODE(MODE_WRAP)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val), .clear(clear),
    .count(c0), .tc(t0), .wrap(w0), .sat(s0));

  param_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .PRESCALE(1), .MODE(MODE_SAT)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val), .clear(clear),
    .count(c1), .tc(t1), .wrap(w1), .sat(s1));

  param_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .PRESCALE(3), .MODE(MODE_WRAP)) u_pre (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val), .clear(clear),
    .count(c2), .tc(t2), .wrap(w2), .sat(s2));

  // Drive one cycle of inputs at the falling edge; queue what instance id must show after the next rising edge.
  task automatic cyc(input int id, input logic r, input logic cl, input logic ld, input logic [3:0] lv,
                     input logic e, input logic u,
                     input logic [3:0] ec, input logic ew, input logic es, input logic et, input string nm);
    exp_t x;
    @(negedge clk);
    rst = r; clear = cl; load = ld; load_val = lv; en = e; up = u;
    @(posedge clk);
    x.id  = id;
    x.exp = {ec, ew, es, et};
    x.nm  = nm;
    q.push_back(x);
  endtask

  // Monitor: outputs are sampled 2 time units after each rising edge, while inputs are still stable.
  initial begin
    exp_t       x;
    logic [6:0] got;
    forever begin
      @(posedge clk);
      #2;
      while (q.size() > 0) begin
        x = q.pop_front();
        case (x.id)
          0:       got = {c0, w0, s0, t0};
          1:       got = {c1, w1, s1, t1};
          default: got = {c2, w2, s2, t2};
        endcase
        n_cmp++;
        if (got !== x.exp) begin
          n_bad++;
          $display("FAIL %s inst=%0d got count=%0d wrap=%b sat=%b tc=%b expected count=%0d wrap=%b sat=%b tc=%b",
                   x.nm, x.id, got[6:3], got[2], got[1], got[0],
                   x.exp[6:3], x.exp[2], x.exp[1], x.exp[0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired count=%0d expected=finished", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with en=1 so a missing reset would step the counters.
    cyc(0, 1, 0, 0, 4'd0, 1, 1, 4'd0, 0, 0, 0, "rst_wrap");
    cyc(1, 1, 0, 0, 4'd0, 1, 1, 4'd0, 0, 0, 0, "rst_sat");
    cyc(2, 1, 0, 0, 4'd0, 1, 1, 4'd0, 0, 0, 0, "rst_pre");

    // Up count 0..9 then wrap to 0 with a one-cycle pulse.
    for (int i = 1; i <= 9; i++)
      cyc(0, 0, 0, 0, 4'd0, 1, 1, 4'(i), 0, 0, (i == 9), "up_count");
    cyc(0, 0, 0, 0, 4'd0, 1, 1, 4'd0, 1, 0, 0, "up_wrap");
    cyc(0, 0, 0, 0, 4'd0, 1, 1, 4'd1, 0, 0, 0, "wrap_pulse_end");

    // Down from 0 wraps to MAX_VAL; load clamps; clear beats load.
    cyc(0, 0, 1, 0, 4'd0, 1, 0, 4'd0, 0, 0, 1, "clear_tc_down");
    cyc(0, 0, 0, 0, 4'd0, 1, 0, 4'd9, 1, 0, 0, "down_wrap");
    cyc(0, 0, 0, 0, 4'd0, 1, 0, 4'd8, 0, 0, 0, "down_step");
    cyc(0, 0, 0, 1, 4'd15, 0, 1, 4'd9, 0, 0, 1, "load_clamp");
    cyc(0, 0, 1, 1, 4'd7, 0, 1, 4'd0, 0, 0, 0, "clear_over_load");
    cyc(0, 0, 0, 1, 4'd3, 1, 1, 4'd3, 0, 0, 0, "load_over_step");
    cyc(0, 0, 0, 0, 4'd0, 1, 1, 4'd4, 0, 0, 0, "dir_up");
    cyc(0, 0, 0, 0, 4'd0, 1, 0, 4'd3, 0, 0, 0, "dir_change");
    cyc(0, 0, 0, 0, 4'd0, 0, 0, 4'd3, 0, 0, 0, "en_low_hold");

    // Saturation at both limits; sat cleared by a successful step or a load.
    cyc(1, 0, 0, 1, 4'd8, 0, 1, 4'd8, 0, 0, 0, "sat_load8");
    cyc(1, 0, 0, 0, 4'd0, 1, 1, 4'd9, 0, 0, 1, "sat_to_top");
    cyc(1, 0, 0, 0, 4'd0, 1, 1, 4'd9, 0, 1, 1, "sat_hold_top");
    cyc(1, 0, 0, 0, 4'd0, 1, 1, 4'd9, 0, 1, 1, "sat_hold_top2");
    cyc(1, 0, 0, 0, 4'd0, 1, 0, 4'd8, 0, 0, 0, "sat_step_down");
    cyc(1, 0, 0, 1, 4'd1, 0, 0, 4'd1, 0, 0, 0, "sat_load1");
    cyc(1, 0, 0, 0, 4'd0, 1, 0, 4'd0, 0, 0, 1, "sat_to_zero");
    cyc(1, 0, 0, 0, 4'd0, 1, 0, 4'd0, 0, 1, 1, "sat_hold_zero");
    cyc(1, 0, 0, 1, 4'd5, 0, 0, 4'd5, 0, 0, 0, "sat_load_clears");

    // PRESCALE=3: step on every third enabled edge, phase frozen while en=0, load re-phases.
    cyc(2, 0, 1, 0, 4'd0, 1, 1, 4'd0, 0, 0, 0, "pre_clear");
    cyc(2, 0, 0, 0, 4'd0, 1, 1, 4'd0, 0, 0, 0, "pre_e1");
    cyc(2, 0, 0, 0, 4'd0, 1, 1, 4'd0, 0, 0, 0, "pre_e2");
    cyc(2, 0, 0, 0, 4'd0, 1, 1, 4'd1, 0, 0, 0, "pre_e3");
    cyc(2, 0, 0, 0, 4'd0, 1, 1, 4'd1, 0, 0, 0, "pre_e4");
    cyc(2, 0, 0, 0, 4'd0, 1, 1, 4'd1, 0, 0, 0, "pre_e5");
    cyc(2, 0, 0, 0, 4'd0, 1, 1, 4'd2, 0, 0, 0, "pre_e6");
    cyc(2, 0, 0, 0, 4'd0, 1, 1, 4'd2, 0, 0, 0, "pre_e7");
    cyc(2, 0, 0, 0, 4'd0, 0, 1, 4'd2, 0, 0, 0, "pre_hold1");
    cyc(2, 0, 0, 0, 4'd0, 0, 1, 4'd2, 0, 0, 0, "pre_hold2");
    cyc(2, 0, 0, 0, 4'd0, 1, 1, 4'd2, 0, 0, 0, "pre_e8");
    cyc(2, 0, 0, 0, 4'd0, 1, 1, 4'd3, 0, 0, 0, "pre_e9");
    cyc(2, 0, 0, 0, 4'd0, 1, 1, 4'd3, 0, 0, 0, "pre_e10");
    cyc(2, 0, 0, 1, 4'd5, 1, 1, 4'd5, 0, 0, 0, "pre_load");
    cyc(2, 0, 0, 0, 4'd0, 1, 1, 4'd5, 0, 0, 0, "pre_l1");
    cyc(2, 0, 0, 0, 4'd0, 1, 1, 4'd5, 0, 0, 0, "pre_l2");
    cyc(2, 0, 0, 0, 4'd0, 1, 1, 4'd6, 0, 0, 0, "pre_l3");

    // Reset overrides a simultaneous load and step.
    cyc(0, 0, 0, 1, 4'd5, 0, 1, 4'd5, 0, 0, 0, "mid_load5");
    cyc(0, 1, 0, 1, 4'd7, 1, 1, 4'd0, 0, 0, 0, "mid_rst");
    cyc(0, 0, 0, 0, 4'd0, 1, 1, 4'd1, 0, 0, 0, "post_rst_step");

    @(negedge clk);
    en = 1'b0; load = 1'b0; clear = 1'b0; rst = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
